// File: rtl/regfile_dump_if.sv
// Bus between the register-file dump engine and its requester: start/abort
// control, the register-file read port, the valid/ready beat stream and status.
interface regfile_dump_if;
    logic        start;
    logic        abort;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    // Requester / register-file side.
    modport master (
        output start, abort, rd, out_ready,
        input  ra, out_valid, out_addr, out_data, busy, done, checksum
    );

    // Dump engine side.
    modport slave (
        input  start, abort, rd, out_ready,
        output ra, out_valid, out_addr, out_data, busy, done, checksum
    );
endinterface

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks indices FIRST_REG..LAST_REG through a
// combinational read port and streams each (index, value) pair as a
// valid/ready beat, keeping a running XOR of the accepted data.
module regfile_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input logic           clk_i,
    input logic           reset_i,
    regfile_dump_if.slave bus
);
    localparam logic [4:0] FirstIdx = 5'(FIRST_REG);
    localparam logic [4:0] LastIdx  = 5'(LAST_REG);

    typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  ra_q, ra_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_addr_q, out_addr_d;
    logic [31:0] out_data_q, out_data_d;
    logic [31:0] checksum_q, checksum_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic start_ok;
    logic last_beat;

    // abort wins over a simultaneous start in IDLE
    assign start_ok  = (state_q == StIdle) && bus.start && !bus.abort;
    // ra still points at the beat on offer while in SEND
    assign last_beat = (ra_q == LastIdx);

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; abort has priority over the handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = bus.abort ? StIdle : StSend;
            end
            StSend: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (bus.out_ready) begin
                    state_d = last_beat ? StDone : StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Next values for the registered datapath and status outputs.
    always_comb begin
        ra_d        = ra_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        checksum_d  = checksum_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    ra_d       = FirstIdx;
                    checksum_d = '0;
                end
            end
            StFetch: begin
                if (bus.abort) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_addr_d  = ra_q;
                    out_data_d  = bus.rd;
                    out_valid_d = 1'b1;
                end
            end
            StSend: begin
                if (bus.abort) begin
                    out_valid_d = 1'b0;
                end else if (bus.out_ready) begin
                    checksum_d  = checksum_q ^ out_data_q;
                    out_valid_d = 1'b0;
                    // stop at the last index; ra never wraps
                    if (!last_beat) begin
                        ra_d = ra_q + 5'd1;
                    end
                end
            end
            StDone: begin
                out_valid_d = 1'b0;
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
        // Status flags follow the upcoming state so they are registered too.
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // Output registers; reset clears everything regardless of handshake.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ra_q        <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            checksum_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ra_q        <= ra_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            checksum_q  <= checksum_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.ra        = ra_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.checksum  = checksum_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a full-range instance checked every cycle against a
// beat-level model, plus a single-register instance checked with literals.
module tb_regfile_dump;
    localparam int unsigned First1 = 0;
    localparam int unsigned Last1  = 31;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_dump_if if1();
    regfile_dump_if if2();

    logic [31:0] regs1 [32];
    logic [31:0] regs2 [32];

    // Combinational register-file read ports.
    assign if1.rd = regs1[if1.ra];
    assign if2.rd = regs2[if2.ra];

    regfile_dump #(.FIRST_REG(First1), .LAST_REG(Last1)) u_dut_full (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (if1)
    );

    regfile_dump #(.FIRST_REG(5), .LAST_REG(5)) u_dut_one (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (if2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Beat-level model: a dump is a list of indices First1..Last1, each beat
    // carries regs1[index], checksum is the XOR of beats taken so far.
    bit          m_in_dump = 0;
    logic [5:0]  m_next    = '0;
    logic [31:0] m_xor     = '0;
    int          m_beats   = 0;
    int          m_dones   = 0;
    bit          p_hold    = 0;
    bit          p_done    = 0;
    logic [4:0]  p_addr    = '0;
    logic [31:0] p_data    = '0;

    // Compare process: inputs change just after posedge, so negedge values
    // are exactly what the next posedge will see.
    always @(negedge clk) begin
        if (reset) begin
            m_in_dump = 0;
            m_xor     = '0;
            m_beats   = 0;
            p_hold    = 0;
            p_done    = 0;
        end else begin
            check("busy", 32'(if1.busy), 32'(m_in_dump));
            check("checksum", if1.checksum, m_xor);
            if (!m_in_dump) check("idle_valid", 32'(if1.out_valid), 32'd0);
            if (p_hold) begin
                check("hold_valid", 32'(if1.out_valid), 32'd1);
                check("hold_addr", 32'(if1.out_addr), 32'(p_addr));
                check("hold_data", if1.out_data, p_data);
            end
            if (if1.done) begin
                check("done_in_dump", 32'(m_in_dump), 32'd1);
                check("done_after_last", 32'(m_next), 32'(Last1 + 1));
                check("done_one_cycle", 32'(p_done), 32'd0);
                m_dones++;
            end
            if (m_in_dump && if1.out_valid) check("ra_tracks", 32'(if1.ra), 32'(m_next[4:0]));
            if (m_in_dump && if1.out_valid && if1.out_ready && !if1.abort) begin
                check("beat_addr", 32'(if1.out_addr), 32'(m_next));
                check("beat_data", if1.out_data, regs1[m_next[4:0]]);
                m_xor   = m_xor ^ regs1[m_next[4:0]];
                m_next  = m_next + 6'd1;
                m_beats++;
            end
            p_hold = m_in_dump && if1.out_valid && !if1.out_ready && !if1.abort;
            p_addr = if1.out_addr;
            p_data = if1.out_data;
            p_done = if1.done;
            if (m_in_dump && (if1.abort || if1.done)) begin
                m_in_dump = 0;
            end else if (!m_in_dump && if1.start && !if1.abort) begin
                m_in_dump = 1;
                m_next    = 6'(First1);
                m_xor     = '0;
                m_beats   = 0;
            end
        end
    end

    // Run the full-range DUT until done; optional random ready and start spam.
    task automatic run_dump(input bit rnd_ready, input bit spam_start);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if1.start = spam_start ? ((i % 3) == 1) : 1'b0;
            if (rnd_ready) if1.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (if1.done) begin
                seen = 1;
                break;
            end
        end
        check("dump_done_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #2;
        if1.start     = 1'b0;
        if1.out_ready = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ra"}, 32'(if1.ra), 32'd0);
        check({tag, "_valid"}, 32'(if1.out_valid), 32'd0);
        check({tag, "_addr"}, 32'(if1.out_addr), 32'd0);
        check({tag, "_data"}, if1.out_data, 32'd0);
        check({tag, "_busy"}, 32'(if1.busy), 32'd0);
        check({tag, "_done"}, 32'(if1.done), 32'd0);
        check({tag, "_checksum"}, if1.checksum, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d0;
        bit  found;
        for (int i = 0; i < 32; i++) begin
            regs1[i] = 32'(i) * 32'h1111_1111;
            regs2[i] = 32'(i) * 32'h0101_0101;
        end
        regs2[5] = 32'hDEAD_BEEF;
        reset = 1'b1;
        if1.start = 1'b0; if1.abort = 1'b0; if1.out_ready = 1'b0;
        if2.start = 1'b0; if2.abort = 1'b0; if2.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");

        // Full dump, ready always high; start honoured on first edge after reset.
        reset = 1'b0;
        if1.start = 1'b1;
        if1.out_ready = 1'b1;
        d0 = m_dones;
        @(posedge clk);
        #2;
        if1.start = 1'b0;
        check("t1_busy_after_start", 32'(if1.busy), 32'd1);
        check("t1_fetch_no_valid", 32'(if1.out_valid), 32'd0);
        @(posedge clk);
        #2;
        check("t1_first_valid", 32'(if1.out_valid), 32'd1);
        check("t1_first_addr", 32'(if1.out_addr), 32'd0);
        check("t1_first_data", if1.out_data, 32'd0);
        run_dump(0, 0);
        check("t1_beats", 32'(m_beats), 32'd32);
        check("t1_dones", 32'(m_dones - d0), 32'd1);
        check("t1_checksum", if1.checksum, 32'h1111_1100);

        // Random backpressure with start pulses while busy.
        d0 = m_dones;
        if1.start = 1'b1;
        run_dump(1, 1);
        repeat (4) @(posedge clk);
        #2;
        check("t2_beats", 32'(m_beats), 32'd32);
        check("t2_dones", 32'(m_dones - d0), 32'd1);
        check("t2_checksum", if1.checksum, 32'h1111_1100);
        check("t2_idle_busy", 32'(if1.busy), 32'd0);

        // Abort while beat 10 is on offer, with ready high.
        d0 = m_dones;
        if1.start = 1'b1;
        @(posedge clk);
        #2;
        if1.start = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (if1.out_valid && if1.out_addr == 5'd10) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #2;
        end
        check("t3_reach_beat10", 32'(found), 32'd1);
        if1.abort = 1'b1;
        @(posedge clk);
        #2;
        if1.abort = 1'b0;
        check("t3_valid_low", 32'(if1.out_valid), 32'd0);
        check("t3_busy_low", 32'(if1.busy), 32'd0);
        check("t3_no_done", 32'(if1.done), 32'd0);
        check("t3_checksum", if1.checksum, 32'h1111_1111);
        // abort together with start in IDLE keeps it idle
        if1.abort = 1'b1;
        if1.start = 1'b1;
        @(posedge clk);
        #2;
        if1.abort = 1'b0;
        if1.start = 1'b0;
        check("t3_abort_start_idle", 32'(if1.busy), 32'd0);
        @(posedge clk);
        #2;
        check("t3_dones", 32'(m_dones - d0), 32'd0);

        // Asynchronous reset between edges mid-dump, then a full dump.
        if1.start = 1'b1;
        @(posedge clk);
        #2;
        if1.start = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (if1.out_valid && if1.out_addr == 5'd5) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #2;
        end
        check("t4_reach_beat5", 32'(found), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_zero("t4_async");
        @(posedge clk);
        #2;
        reset = 1'b0;
        if1.start = 1'b1;
        d0 = m_dones;
        run_dump(0, 0);
        check("t4_beats", 32'(m_beats), 32'd32);
        check("t4_dones", 32'(m_dones - d0), 32'd1);
        check("t4_checksum", if1.checksum, 32'h1111_1100);

        // Single-register instance.
        if2.out_ready = 1'b1;
        if2.start = 1'b1;
        @(posedge clk);
        #2;
        if2.start = 1'b0;
        check("t5_busy", 32'(if2.busy), 32'd1);
        check("t5_fetch_no_valid", 32'(if2.out_valid), 32'd0);
        @(posedge clk);
        #2;
        check("t5_valid", 32'(if2.out_valid), 32'd1);
        check("t5_addr", 32'(if2.out_addr), 32'd5);
        check("t5_data", if2.out_data, 32'hDEAD_BEEF);
        check("t5_ra", 32'(if2.ra), 32'd5);
        @(posedge clk);
        #2;
        check("t5_valid_drop", 32'(if2.out_valid), 32'd0);
        check("t5_done", 32'(if2.done), 32'd1);
        check("t5_checksum", if2.checksum, 32'hDEAD_BEEF);
        @(posedge clk);
        #2;
        check("t5_done_pulse", 32'(if2.done), 32'd0);
        check("t5_idle", 32'(if2.busy), 32'd0);
        check("t5_checksum_hold", if2.checksum, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
